// File: rtl/jl_accum_responder.sv
// Far-end responder for the jleightcap uio accumulator bus: accumulator, degree-log FIFO, halt/done.
// Optional feature macro: ACC_SAT_EN (saturating accumulator add instead of modulo-256 wrap).
module jl_accum_responder #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [7:0]  ACC_INIT = 8'h00
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  bus_in_i,
    input  logic        bus_oe_i,
    input  logic [7:0]  degree_in_i,
    input  logic        clear_i,
    output logic [7:0]  acc_out_o,
    output logic        acc_oe_o,
    output logic        halted_o,
    output logic        done_o,
    input  logic        rd_en_i,
    output logic [7:0]  rd_data_o,
    output logic        rd_valid_o,
    output logic        ovf_o,
    output logic [15:0] wr_cnt_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [AW:0]   CntFull = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CntOne  = (AW+1)'(1);
    localparam logic [AW-1:0] PtrOne  = AW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHalted
    } state_e;

    state_e        state_q;
    logic [7:0]    acc_q, acc_d;
    logic          halted_q;
    logic          done_q;
    logic          ovf_q;
    logic [15:0]   wr_cnt_q;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q, cnt_d;

    logic          wr_accept;
    logic          wr_halt;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push_ok;
    logic          push_drop;
    logic          pop_ok;
    logic [8:0]    sum;

    // Writes are only honoured while the core is driving and the block is not halted.
    assign wr_accept = bus_oe_i && bus_in_i[7] && (state_q != StHalted);
    assign wr_halt   = wr_accept && bus_in_i[6];

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CntFull);
    assign pop_ok     = rd_en_i && !fifo_empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign push_ok    = wr_accept && (!fifo_full || pop_ok);
    assign push_drop  = wr_accept && fifo_full && !pop_ok;

    assign sum = {1'b0, acc_q} + {3'b000, bus_in_i[5:0]};

    always_comb begin
        acc_d = sum[7:0];
`ifdef ACC_SAT_EN
        if (sum[8]) begin
            acc_d = 8'hFF;
        end
`endif
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CntOne;
            2'b01:   cnt_d = cnt_q - CntOne;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q  <= StIdle;
            acc_q    <= ACC_INIT;
            halted_q <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            wr_cnt_q <= 16'h0000;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (wr_accept) begin
                        state_q <= wr_halt ? StHalted : StRun;
                    end
                end
                StRun: begin
                    if (wr_halt) begin
                        state_q <= StHalted;
                    end
                end
                StHalted: begin
                    state_q <= StHalted;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase

            if (wr_halt) begin
                halted_q <= 1'b1;
                done_q   <= 1'b1;
            end
            if (wr_accept) begin
                acc_q    <= acc_d;
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
            if (push_drop) begin
                ovf_q <= 1'b1;
            end
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= degree_in_i;
        end
    end

    assign acc_out_o  = acc_q;
    assign acc_oe_o   = ~bus_oe_i;
    assign halted_o   = halted_q;
    assign done_o     = done_q;
    assign rd_valid_o = !fifo_empty;
    assign rd_data_o  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
    assign ovf_o      = ovf_q;
    assign wr_cnt_o   = wr_cnt_q;

endmodule

// File: tb/tb_jl_accum_responder.sv
// Bench for jl_accum_responder: FIFO pops checked by a scoreboard monitor, status by directed checks.
module tb_jl_accum_responder;

    logic        clk;
    logic        rst;
    logic [7:0]  bus_in;
    logic        bus_oe;
    logic [7:0]  degree_in;
    logic        clear;
    logic [7:0]  acc_out;
    logic        acc_oe;
    logic        halted;
    logic        done;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        ovf;
    logic [15:0] wr_cnt;

    // Second instance with a non-zero ACC_INIT for the wrap/saturate case.
    logic [7:0]  f_bus_in;
    logic        f_bus_oe;
    logic [7:0]  f_acc_out;
    logic        f_acc_oe;
    logic        f_halted;
    logic        f_done;
    logic [7:0]  f_rd_data;
    logic        f_rd_valid;
    logic        f_ovf;
    logic [15:0] f_wr_cnt;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    jl_accum_responder #(.DEPTH(8), .ACC_INIT(8'h00)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus_in_i    (bus_in),
        .bus_oe_i    (bus_oe),
        .degree_in_i (degree_in),
        .clear_i     (clear),
        .acc_out_o   (acc_out),
        .acc_oe_o    (acc_oe),
        .halted_o    (halted),
        .done_o      (done),
        .rd_en_i     (rd_en),
        .rd_data_o   (rd_data),
        .rd_valid_o  (rd_valid),
        .ovf_o       (ovf),
        .wr_cnt_o    (wr_cnt)
    );

    jl_accum_responder #(.DEPTH(8), .ACC_INIT(8'hF0)) dut_f0 (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus_in_i    (f_bus_in),
        .bus_oe_i    (f_bus_oe),
        .degree_in_i (8'h00),
        .clear_i     (1'b0),
        .acc_out_o   (f_acc_out),
        .acc_oe_o    (f_acc_oe),
        .halted_o    (f_halted),
        .done_o      (f_done),
        .rd_en_i     (1'b0),
        .rd_data_o   (f_rd_data),
        .rd_valid_o  (f_rd_valid),
        .ovf_o       (f_ovf),
        .wr_cnt_o    (f_wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every cycle that will pop, the head must match the scoreboard.
    always @(negedge clk) begin
        if (!rst && !clear && rd_en && rd_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %02h, scoreboard empty", rd_data);
            end else begin
                if (rd_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL pop_data: got %02h expected %02h", rd_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] b, input logic [7:0] deg);
        bus_in    = b;
        bus_oe    = 1'b1;
        degree_in = deg;
        tick();
        bus_in    = 8'h00;
        bus_oe    = 1'b0;
        degree_in = 8'h00;
    endtask

    task automatic pop_n(input int n);
        rd_en = 1'b1;
        for (int i = 0; i < n; i++) tick();
        rd_en = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; bus_in = 8'h00; bus_oe = 1'b0; degree_in = 8'h00;
        rd_en = 1'b0; f_bus_in = 8'h00; f_bus_oe = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // 1. Reset state
        check("rst_acc", acc_out, 8'h00);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_halted", halted, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_wr_cnt", wr_cnt, 16'h0);
        check("rst_acc_oe", acc_oe, 1'b1);
        check("rst_acc_f0", f_acc_out, 8'hF0);

        // 2. Accumulate three count=5 writes
        bus_oe = 1'b1;
        #1;
        check("acc_oe_driven", acc_oe, 1'b0);
        bus_oe = 1'b0;
        wr(8'h85, 8'h01); exp_q.push_back(8'h01);
        check("acc_first", acc_out, 8'h05);
        wr(8'h85, 8'h02); exp_q.push_back(8'h02);
        wr(8'h85, 8'h03); exp_q.push_back(8'h03);
        check("acc_sum", acc_out, 8'h0F);
        check("acc_wr_cnt", wr_cnt, 16'd3);
        wr(8'h05, 8'hEE);
        check("we0_acc", acc_out, 8'h0F);
        check("we0_wr_cnt", wr_cnt, 16'd3);
        pop_n(3);
        check("drain_valid", rd_valid, 1'b0);
        pop_n(1);
        check("empty_pop_valid", rd_valid, 1'b0);

        // 3. Wrap / saturate on the F0 instance
        f_bus_in = 8'hA0; f_bus_oe = 1'b1;
        tick();
`ifdef ACC_SAT_EN
        check("f0_first", f_acc_out, 8'hFF);
`else
        check("f0_first", f_acc_out, 8'h10);
`endif
        tick();
        f_bus_oe = 1'b0;
`ifdef ACC_SAT_EN
        check("f0_second", f_acc_out, 8'hFF);
`else
        check("f0_second", f_acc_out, 8'h30);
`endif
        check("f0_wr_cnt", f_wr_cnt, 16'd2);

        // 4. Halt from RUN
        wr(8'hC3, 8'h04); exp_q.push_back(8'h04);
        check("halt_acc", acc_out, 8'h12);
        check("halt_level", halted, 1'b1);
        check("halt_done", done, 1'b1);
        check("halt_wr_cnt", wr_cnt, 16'd4);
        tick();
        check("done_pulse_end", done, 1'b0);
        wr(8'h81, 8'h09);
        check("halted_acc", acc_out, 8'h12);
        check("halted_wr_cnt", wr_cnt, 16'd4);
        check("halted_done", done, 1'b0);
        check("halted_still", halted, 1'b1);
        pop_n(1);
        check("halted_drain", rd_valid, 1'b0);

        // 5a. Overflow: nine writes, first eight kept
        do_clear();
        check("clr_halted", halted, 1'b0);
        check("clr_acc", acc_out, 8'h00);
        check("clr_wr_cnt", wr_cnt, 16'd0);
        for (int i = 0; i < 9; i++) begin
            wr(8'h81, 8'h10 + 8'(i));
            if (i < 8) exp_q.push_back(8'h10 + 8'(i));
        end
        check("ovf_set", ovf, 1'b1);
        check("ovf_wr_cnt", wr_cnt, 16'd9);
        check("ovf_acc", acc_out, 8'h09);
        pop_n(8);
        check("ovf_drain", rd_valid, 1'b0);
        check("ovf_sticky", ovf, 1'b1);

        // 5b. Full + push + pop in one cycle
        do_clear();
        check("clr_ovf", ovf, 1'b0);
        for (int i = 0; i < 8; i++) begin
            wr(8'h81, 8'h20 + 8'(i));
            exp_q.push_back(8'h20 + 8'(i));
        end
        rd_en = 1'b1;
        wr(8'h81, 8'h28); exp_q.push_back(8'h28);
        rd_en = 1'b0;
        check("fullpp_ovf", ovf, 1'b0);
        check("fullpp_wr_cnt", wr_cnt, 16'd9);
        pop_n(8);
        check("fullpp_drain", rd_valid, 1'b0);

        // 5c. Empty + push + pop: only the push happens
        rd_en = 1'b1;
        wr(8'h81, 8'h33); exp_q.push_back(8'h33);
        rd_en = 1'b0;
        check("emptypp_valid", rd_valid, 1'b1);
        check("emptypp_data", rd_data, 8'h33);
        pop_n(1);

        // 6. Clear with a write in the same cycle discards the write
        clear = 1'b1;
        wr(8'h85, 8'h44);
        clear = 1'b0;
        check("midclr_acc", acc_out, 8'h00);
        check("midclr_valid", rd_valid, 1'b0);
        check("midclr_wr_cnt", wr_cnt, 16'd0);
        wr(8'h82, 8'h07); exp_q.push_back(8'h07);
        check("midclr_next_acc", acc_out, 8'h02);
        check("midclr_next_cnt", wr_cnt, 16'd1);
        check("midclr_halted", halted, 1'b0);
        pop_n(1);

        // IDLE -> HALTED directly, then rst recovers
        do_clear();
        wr(8'hC1, 8'h55); exp_q.push_back(8'h55);
        check("idle_halt", halted, 1'b1);
        check("idle_halt_done", done, 1'b1);
        check("idle_halt_acc", acc_out, 8'h01);
        pop_n(1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_halt_clr", halted, 1'b0);
        check("rst_acc_again", acc_out, 8'h00);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
